serial_tx: RTL
==============

// Module: serial_tx
// PURPOSE
//  Transmit side of the team's single-wire serial link; the sampling receiver is the other end.
//  Accepts a WIDTH-bit word over a valid/ready handshake and serializes it on tx_line.
//  Frame: start (0), data LSB first, optional even-parity bit, stop (1).
//  Every bit is held for CLKS_PER_BIT clocks. Sits between a local producer and the line driver.
// PARAMETERS
//  WIDTH         8  data bits per frame (>=1)
//  CLKS_PER_BIT  4  clocks each bit is held on tx_line (>=1); counter width $clog2(CLKS_PER_BIT)+1
// PORTS
//  clk       in   1      single clock; all state on posedge
//  rst_n     in   1      asynchronous active-low reset
//  tx_data   in   WIDTH  word to send; sampled only at accept
//  tx_valid  in   1      producer has a word
//  tx_ready  out  1      block can accept; accept = tx_valid & tx_ready at posedge
//  tx_line   out  1      serial output; idles high
//  busy      out  1      high from the cycle after accept through the last stop-bit cycle
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, tx_line=1, tx_ready=0, busy=0, shift reg and counters=0.
//   - tx_ready rises on the first posedge after rst_n deasserts.
//  States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  IDLE: tx_line=1, tx_ready=1, busy=0.
//   - On accept: latch tx_data, go to START.
//   - tx_line=0 from the next cycle (1-cycle latency accept->start edge).
//  START: tx_line=0 for CLKS_PER_BIT cycles, then DATA.
//  DATA: bit i = latched[i], i=0..WIDTH-1, each for CLKS_PER_BIT cycles.
//   - After bit WIDTH-1: go to PARITY if compiled in, else STOP.
//  PARITY: tx_line = ^latched (even parity) for CLKS_PER_BIT cycles, then STOP.
//  STOP: tx_line=1 for CLKS_PER_BIT cycles, then IDLE.
//  Registered outputs; tx_ready=0 and busy=1 in all non-IDLE states.
//  Frame time: (WIDTH+2[+1]) * CLKS_PER_BIT cycles.
//   - Minimum spacing between frame starts is frame time + 1 cycle, i.e. at least one
//     idle-high IDLE cycle between back-to-back frames.
//  Boundaries:
//   - tx_valid while busy: ignored; no queuing; the producer holds tx_valid until accepted.
//   - tx_data changes during a frame: no effect on the frame being sent.
//   - CLKS_PER_BIT=1: one clock per bit with no extra stall.
//   - Bit counter wraps only via the state change; no overflow is possible.
//   - rst_n low mid-frame: tx_line=1 immediately (async), frame abandoned, nothing resumes after reset.
//   - tx_valid high during reset: not accepted; accept is possible only once tx_ready is high.
// CONFIGURATION
//  SERIAL_TX_PARITY_EN defined: PARITY state present; frame = WIDTH+3 bits.
//  SERIAL_TX_PARITY_EN undefined: no PARITY state; DATA goes straight to STOP; frame = WIDTH+2 bits.
//  Ports are identical in both builds.
// TESTING (WIDTH=8, CLKS_PER_BIT=4)
//  1 Reset: rst_n=0 with clk running -> tx_line=1, tx_ready=0, busy=0; rst_n=1 -> tx_ready=1 after 1 posedge.
//  2 Single frame: send 0xA5, no parity -> line 0,1,0,1,0,0,1,0,1,1, each bit 4 clks;
//    busy high 40 clks; then tx_ready=1.
//  3 Parity build: send 0xA5 -> parity bit 0; send 0x07 -> parity bit 1; frame = 44 clks.
//  4 Back-to-back: tx_valid held high, words 0x00 then 0xFF -> exactly 1 idle-high cycle
//    between the stop of frame 1 and the start of frame 2; both decode correctly.
//  5 Hold/ignore: change tx_data to 0x3C mid-frame and pulse tx_valid while busy ->
//    frame still 0xA5; no extra frame sent.
//  6 Reset mid-frame: rst_n=0 during data bit 3 -> tx_line=1 at once, busy=0;
//    after release -> idle line, no residual bits, the next accepted word sends cleanly.

Source files
------------

// File: rtl/serial_tx.sv
// -----------------------------------------------------------------------------
// serial_tx
// Transmit side of the single-wire serial link. A WIDTH-bit word is accepted
// over a valid/ready handshake and sent on tx_line as:
//   start (0), data LSB first, [even parity], stop (1)
// Each bit is held for CLKS_PER_BIT clocks. The line idles high.
//
// Optional feature: define SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (frame = WIDTH+3 bits instead of
// WIDTH+2). Ports are identical in both builds.
//
// Ports:
//   clk       in   1      clock, all state on posedge
//   rst_n     in   1      asynchronous active-low reset
//   tx_data   in   WIDTH  word to send, sampled only at accept
//   tx_valid  in   1      producer has a word
//   tx_ready  out  1      block can accept (accept = tx_valid & tx_ready)
//   tx_line   out  1      serial output, idles high
//   busy      out  1      high from the cycle after accept to the last stop cycle
// -----------------------------------------------------------------------------
module serial_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             tx_line,
    output logic             busy
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [CW-1:0]    r_cnt;
    logic [BW-1:0]    r_bit;
    logic             r_line;
    logic             r_ready;
    logic             r_busy;
`ifdef SERIAL_TX_PARITY_EN
    logic             r_parity;
`endif

    wire w_bit_done = (r_cnt == CNT_LAST);

    // The value driven onto the line is decided one cycle ahead, at the
    // transition into each bit, so tx_line is a plain register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_shift  <= '0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_line   <= 1'b1;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_line  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_cnt   <= '0;
                    r_bit   <= '0;
                    // r_ready is still low on the first cycle after reset,
                    // so a tx_valid held through reset is not taken early.
                    if (tx_valid && r_ready) begin
                        r_shift <= tx_data;
`ifdef SERIAL_TX_PARITY_EN
                        r_parity <= ^tx_data;
`endif
                        r_state <= S_START;
                        r_line  <= 1'b0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                        r_line  <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_done) begin
                        r_cnt <= '0;
                        if (r_bit == BIT_LAST) begin
`ifdef SERIAL_TX_PARITY_EN
                            r_state <= S_PARITY;
                            r_line  <= r_parity;
`else
                            r_state <= S_STOP;
                            r_line  <= 1'b1;
`endif
                        end else begin
                            r_bit   <= r_bit + BW'(1);
                            r_line  <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

`ifdef SERIAL_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_cnt   <= '0;
                        r_state <= S_STOP;
                        r_line  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`endif

                S_STOP: begin
                    if (w_bit_done) begin
                        // Return to IDLE with ready already high: this gives the
                        // single idle-high cycle between back-to-back frames.
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_line  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_line  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign tx_line  = r_line;
    assign tx_ready = r_ready;
    assign busy     = r_busy;

endmodule
